// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: owns the PC, walks each instruction through
// FETCH/DECODE, and resolves jump, conditional-branch and halt opcodes.
module pc_seq_ctrl #(
    parameter int unsigned     PC_W    = 16,
    parameter logic [5:0]      OP_JMP  = 6'b110000,
    parameter logic [5:0]      OP_BRZ  = 6'b110001,
    parameter logic [5:0]      OP_BRNZ = 6'b110010,
    parameter logic [5:0]      OP_HALT = 6'b111111,
    parameter logic [PC_W-1:0] RST_PC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      ireg_op,
    input  logic [PC_W-1:0] target,
    input  logic            zero_flag,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      pc_src,
    output logic            fetch_req,
    output logic            ir_load,
    output logic            flush,
    output logic            halted
);

    localparam logic [1:0] SRC_TARGET = 2'b00;
    localparam logic [1:0] SRC_INC    = 2'b01;
    localparam logic [1:0] SRC_HOLD   = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_HALT   = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [1:0]      r_pc_src;
    logic            r_fetch_req;
    logic            r_ir_load;
    logic            r_flush;
    logic            r_halted;

    logic            w_taken;
    logic            w_fetch_done;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [1:0]      w_pc_src_nxt;
    logic            w_fetch_req_nxt;
    logic            w_ir_load_nxt;
    logic            w_flush_nxt;
    logic            w_halted_nxt;

    // A fetch completes only once the request is actually on the bus.
    assign w_fetch_done = r_fetch_req & imem_ready;
    assign w_pc_inc     = r_pc + PC_W'(1);
    assign w_taken      = (ireg_op == OP_JMP)
                        | ((ireg_op == OP_BRZ)  &  zero_flag)
                        | ((ireg_op == OP_BRNZ) & ~zero_flag);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FETCH;
            r_pc        <= RST_PC;
            r_pc_src    <= SRC_HOLD;
            r_fetch_req <= 1'b0;
            r_ir_load   <= 1'b0;
            r_flush     <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pc_src    <= w_pc_src_nxt;
            r_fetch_req <= w_fetch_req_nxt;
            r_ir_load   <= w_ir_load_nxt;
            r_flush     <= w_flush_nxt;
            r_halted    <= w_halted_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_fetch_done) w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (!stall) begin
                    if (!w_taken && (ireg_op == OP_HALT)) w_state_nxt = ST_HALT;
                    else                                  w_state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (resume) w_state_nxt = ST_FETCH;
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_pc_nxt      = r_pc;
        w_pc_src_nxt  = SRC_HOLD;
        w_ir_load_nxt = 1'b0;
        w_flush_nxt   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_ir_load_nxt = w_fetch_done;
            end
            ST_DECODE: begin
                if (!stall) begin
                    if (w_taken) begin
                        w_pc_nxt     = target;
                        w_pc_src_nxt = SRC_TARGET;
                        w_flush_nxt  = 1'b1;
                    end else if (ireg_op != OP_HALT) begin
                        w_pc_nxt     = w_pc_inc;
                        w_pc_src_nxt = SRC_INC;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_pc_nxt     = w_pc_inc;
                    w_pc_src_nxt = SRC_INC;
                end
            end
            default: ;
        endcase
        w_fetch_req_nxt = (w_state_nxt == ST_FETCH);
        w_halted_nxt    = (w_state_nxt == ST_HALT);
    end

    assign pc        = r_pc;
    assign pc_src    = r_pc_src;
    assign fetch_req = r_fetch_req;
    assign ir_load   = r_ir_load;
    assign flush     = r_flush;
    assign halted    = r_halted;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: a cycle model of the sequencer rules
// is compared every cycle, plus directed literal checks on key scenarios.
module tb_pc_seq_ctrl;

    localparam logic [5:0] NOP  = 6'b000000;
    localparam logic [5:0] JMP  = 6'b110000;
    localparam logic [5:0] BRZ  = 6'b110001;
    localparam logic [5:0] BRNZ = 6'b110010;
    localparam logic [5:0] HLT  = 6'b111111;

    localparam int MF = 0;
    localparam int MD = 1;
    localparam int MH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  ireg_op = NOP;
    logic [15:0] target = '0;
    logic        zero_flag = 1'b0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic        resume = 1'b0;
    logic [15:0] pc;
    logic [1:0]  pc_src;
    logic        fetch_req;
    logic        ir_load;
    logic        flush;
    logic        halted;

    int n_chk  = 0;
    int n_fail = 0;

    pc_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ireg_op(ireg_op), .target(target),
        .zero_flag(zero_flag), .stall(stall), .imem_ready(imem_ready),
        .resume(resume), .pc(pc), .pc_src(pc_src), .fetch_req(fetch_req),
        .ir_load(ir_load), .flush(flush), .halted(halted)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode, pc as an integer, and the pending-request flag.
    int   m_mode;
    int   m_pc;
    int   m_src;
    bit   m_req, m_irl, m_fl, m_hlt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = MF; m_pc = 0; m_src = 3;
            m_req = 0; m_irl = 0; m_fl = 0; m_hlt = 0;
        end else begin
            bit take;
            m_irl = 0; m_fl = 0; m_src = 3;
            if (m_mode == MF) begin
                if (m_req && imem_ready) begin m_irl = 1; m_mode = MD; end
            end else if (m_mode == MD) begin
                if (!stall) begin
                    take = (ireg_op == JMP) || (ireg_op == BRZ && zero_flag)
                        || (ireg_op == BRNZ && !zero_flag);
                    if (take) begin
                        m_pc = int'(target); m_src = 0; m_fl = 1; m_mode = MF;
                    end else if (ireg_op == HLT) begin
                        m_mode = MH;
                    end else begin
                        m_pc = (m_pc + 1) % 65536; m_src = 1; m_mode = MF;
                    end
                end
            end else begin
                if (resume) begin m_pc = (m_pc + 1) % 65536; m_src = 1; m_mode = MF; end
            end
            m_req = (m_mode == MF);
            m_hlt = (m_mode == MH);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_pc", int'(pc), m_pc);
        chk("m_pc_src", int'(pc_src), m_src);
        chk("m_fetch_req", int'(fetch_req), int'(m_req));
        chk("m_ir_load", int'(ir_load), int'(m_irl));
        chk("m_flush", int'(flush), int'(m_fl));
        chk("m_halted", int'(halted), int'(m_hlt));
        chk("strobe_excl", int'(ir_load & flush), 0);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_ir_load();
        int n = 0;
        while (!ir_load && n < 20) begin tick(1); n++; end
        chk("ir_load_wait", int'(ir_load), 1);
    endtask

    // Present an opcode during DECODE and let it resolve on the next edge.
    task automatic exec(input logic [5:0] op, input logic [15:0] tgt, input logic z);
        wait_ir_load();
        ireg_op = op; target = tgt; zero_flag = z;
        tick(1);
    endtask

    logic [15:0] p;

    initial begin
        tick(2);
        chk("rst_pc", int'(pc), 0);
        chk("rst_src", int'(pc_src), 3);
        chk("rst_req", int'(fetch_req), 0);
        chk("rst_halt", int'(halted), 0);
        rst_n = 1'b1; imem_ready = 1'b1;
        tick(1);
        chk("first_req", int'(fetch_req), 1);
        chk("first_irl", int'(ir_load), 0);

        for (int i = 1; i <= 3; i++) begin
            exec(NOP, 16'h0000, 1'b0);
            chk("nop_pc", int'(pc), i);
            chk("nop_src", int'(pc_src), 1);
        end

        exec(JMP, 16'h0100, 1'b0);
        chk("jmp_pc", int'(pc), 16'h0100);
        chk("jmp_src", int'(pc_src), 0);
        chk("jmp_flush", int'(flush), 1);
        tick(1);
        chk("jmp_flush_1cyc", int'(flush), 0);

        exec(BRZ, 16'h0040, 1'b0);
        chk("brz_nt_pc", int'(pc), 16'h0101);
        chk("brz_nt_flush", int'(flush), 0);
        exec(BRZ, 16'h0040, 1'b1);
        chk("brz_t_pc", int'(pc), 16'h0040);
        chk("brz_t_flush", int'(flush), 1);
        exec(BRNZ, 16'h0080, 1'b0);
        chk("brnz_t_pc", int'(pc), 16'h0080);
        exec(BRNZ, 16'h0080, 1'b1);
        chk("brnz_nt_pc", int'(pc), 16'h0081);

        imem_ready = 1'b0;
        p = pc;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("rdy0_req", int'(fetch_req), 1);
            chk("rdy0_pc", int'(pc), int'(p));
        end
        imem_ready = 1'b1;

        wait_ir_load();
        stall = 1'b1; ireg_op = JMP; target = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("stall_pc", int'(pc), 16'h0081);
            chk("stall_src", int'(pc_src), 3);
        end
        stall = 1'b0;
        tick(1);
        chk("stall_rel_pc", int'(pc), 16'h1234);

        exec(HLT, 16'h0000, 1'b0);
        chk("halt_h", int'(halted), 1);
        chk("halt_req", int'(fetch_req), 0);
        tick(3);
        chk("halt_hold", int'(halted), 1);
        chk("halt_pc", int'(pc), 16'h1234);
        resume = 1'b1;
        tick(1);
        resume = 1'b0;
        chk("resume_pc", int'(pc), 16'h1235);
        chk("resume_h", int'(halted), 0);
        chk("resume_req", int'(fetch_req), 1);

        imem_ready = 1'b0; resume = 1'b1;
        tick(2);
        chk("resume_ign_pc", int'(pc), 16'h1235);
        resume = 1'b0; imem_ready = 1'b1;

        exec(JMP, 16'hFFFF, 1'b0);
        exec(NOP, 16'h0000, 1'b0);
        chk("wrap_pc", int'(pc), 16'h0000);

        exec(NOP, 16'h0000, 1'b0);
        exec(JMP, 16'h0001, 1'b0);
        chk("self_pc", int'(pc), 16'h0001);
        chk("self_flush", int'(flush), 1);

        imem_ready = 1'b0;
        tick(2);
        chk("pre_rst_req", int'(fetch_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pc", int'(pc), 0);
        chk("async_req", int'(fetch_req), 0);
        chk("async_src", int'(pc_src), 3);
        chk("async_irl", int'(ir_load), 0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
